// File: rtl/tube_hit_recorder_pkg.sv
// Shared types and default constants for the tube hit recorder.
package tube_hit_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    READOUT = 2'd2
  } state_t;

  localparam int DEF_N_TUBES    = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_WINDOW_MAX = 255;
  localparam int MISS_W         = 8;

endpackage

// File: rtl/tube_hit_channel.sv
// One tube channel: rising-edge detect on the discriminator output and a
// first-hit latch that freezes the window counter value on the first edge.
module tube_hit_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tube,
  input  logic             arm,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic             hit,
  output logic [CNT_W-1:0] hit_time
);

  logic prev;

  // Previous sample runs in every state so a tube already high at arming
  // needs a fresh low->high transition before it counts as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 1'b0;
      hit      <= 1'b0;
      hit_time <= '0;
    end else begin
      prev <= tube;
      if (arm) begin
        hit      <= 1'b0;
        hit_time <= '0;
      end else if (en && tube && !prev && !hit) begin
        hit      <= 1'b1;
        hit_time <= cnt;
      end
    end
  end

endmodule

// File: rtl/tube_hit_recorder.sv
// Tube hit recorder: a coincidence trigger opens a capture window, each tube
// channel latches the time of its first rising edge, and the host reads the
// closed event one channel at a time before releasing it.
// Optional feature: define TUBE_HIT_MISSED_CNT_EN to add the 8-bit saturating
// MISSED_TRIG counter of triggers seen while busy.
module tube_hit_recorder
  import tube_hit_recorder_pkg::*;
#(
  parameter int N_TUBES    = DEF_N_TUBES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WINDOW_MAX = DEF_WINDOW_MAX,
  localparam int SEL_W     = (N_TUBES > 1) ? $clog2(N_TUBES) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SCIN_COINC,
  input  logic [N_TUBES-1:0] TUBE_IN,
  input  logic [SEL_W-1:0]   RD_SEL,
  input  logic               RD_REQ,
  input  logic               EVENT_ACK,
  output logic [CNT_W-1:0]   RD_DATA,
  output logic               RD_VALID,
  output logic               RD_HIT,
  output logic [N_TUBES-1:0] HIT_MASK,
  output logic               EVENT_READY,
  output logic               BUSY
`ifdef TUBE_HIT_MISSED_CNT_EN
  ,
  output logic [MISS_W-1:0]  MISSED_TRIG
`endif
);

  state_t                          state, state_nxt;
  logic   [CNT_W-1:0]              cnt;
  logic   [N_TUBES-1:0][CNT_W-1:0] times;
  logic                            at_end, arm, rd_ok, in_range;
  logic   [6:0]                    sel_ext;

  assign at_end   = (cnt == CNT_W'(WINDOW_MAX));
  assign arm      = (state == IDLE) && SCIN_COINC;
  assign rd_ok    = RD_REQ && (state == READOUT);
  assign sel_ext  = 7'(RD_SEL);
  assign in_range = (sel_ext < 7'(N_TUBES));

  for (genvar g = 0; g < N_TUBES; g++) begin : g_ch
    tube_hit_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .tube     (TUBE_IN[g]),
      .arm      (arm),
      .en       (state == ARMED),
      .cnt      (cnt),
      .hit      (HIT_MASK[g]),
      .hit_time (times[g])
    );
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: trigger only honoured in IDLE, ack only in READOUT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SCIN_COINC) state_nxt = ARMED;
      ARMED:   if (at_end)     state_nxt = READOUT;
      READOUT: if (EVENT_ACK)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Window counter: cleared on arming, stops at WINDOW_MAX rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST)                           cnt <= '0;
    else if (arm)                      cnt <= '0;
    else if (state == ARMED && !at_end) cnt <= cnt + 1'b1;
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      EVENT_READY <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      EVENT_READY <= (state_nxt == READOUT);
      BUSY        <= (state_nxt != IDLE);
    end
  end

  // Read port: one-cycle response; out-of-range channels read as empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
      RD_HIT   <= 1'b0;
    end else begin
      RD_VALID <= rd_ok;
      if (rd_ok) begin
        RD_DATA <= in_range ? times[RD_SEL] : '0;
        RD_HIT  <= in_range && HIT_MASK[RD_SEL];
      end
    end
  end

`ifdef TUBE_HIT_MISSED_CNT_EN
  // Count trigger cycles that arrive while an event is in flight.
  always_ff @(posedge CLK) begin
    if (RST)
      MISSED_TRIG <= '0;
    else if (SCIN_COINC && state != IDLE && MISSED_TRIG != '1)
      MISSED_TRIG <= MISSED_TRIG + 1'b1;
  end
`endif

endmodule

// File: doc/tube_hit_recorder.md
TUBE_HIT_RECORDER -- requirements
Module: tube_hit_recorder

Interface
REQ-001 SHALL have parameter N_TUBES, default 4: number of tube channels, range 1..64.
REQ-002 SHALL have parameter CNT_W, default 8: width of the time counter and of each stored hit time.
REQ-003 SHALL have parameter WINDOW_MAX, default 255: last counter value of the capture window; must be less than 2**CNT_W.
REQ-004 SHALL have port CLK  in  1  system clock, one 20 ns tick per cycle; sole clock of the block.
REQ-005 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have port SCIN_COINC  in  1  scintillator coincidence trigger, level-sampled.
REQ-007 SHALL have port TUBE_IN  in  N_TUBES  tube discriminator outputs.
REQ-008 SHALL have port RD_SEL  in  max(1,clog2(N_TUBES))  channel to read.
REQ-009 SHALL have port RD_REQ  in  1  read strobe, one cycle per read.
REQ-010 SHALL have port EVENT_ACK  in  1  host releases the event.
REQ-011 SHALL have port RD_DATA  out  CNT_W  hit time of selected channel.
REQ-012 SHALL have port RD_VALID  out  1  RD_DATA/RD_HIT qualifier, one-cycle pulse.
REQ-013 SHALL have port RD_HIT  out  1  selected channel fired in this event.
REQ-014 SHALL have port HIT_MASK  out  N_TUBES  per-channel hit flags.
REQ-015 SHALL have port EVENT_READY  out  1  event closed, readable.
REQ-016 SHALL have port BUSY  out  1  high in ARMED and READOUT.

Function
REQ-017 SHALL implement states IDLE, ARMED, READOUT; all outputs registered.
REQ-018 IDLE: SCIN_COINC=1 at an edge -> ARMED next cycle, counter=0, all hit flags and times cleared.
REQ-019 ARMED: counter increments by 1 per cycle; at the edge where counter==WINDOW_MAX -> READOUT; counter never wraps.
REQ-020 Hit on channel i = TUBE_IN[i]==1 with previous-cycle sample 0; the previous-cycle register updates in every state.
REQ-021 The first hit on channel i in ARMED stores the current counter value and sets HIT_MASK[i]; later edges on that channel are ignored.
REQ-022 A hit in the cycle where counter==WINDOW_MAX is captured; a tube already high at arming is not a hit until it falls and rises again.
REQ-023 Simultaneous hits on several channels SHALL all be captured in the same cycle.
REQ-024 SCIN_COINC in ARMED or READOUT SHALL be ignored: no retrigger, no state change.
REQ-025 READOUT: EVENT_READY=1; RD_REQ at an edge -> next cycle RD_VALID=1, RD_DATA=stored time of RD_SEL and RD_HIT=HIT_MASK[RD_SEL]; RD_DATA=0 if that channel did not fire.
REQ-026 RD_SEL >= N_TUBES SHALL return RD_DATA=0 and RD_HIT=0 with RD_VALID=1.
REQ-027 RD_REQ outside READOUT SHALL be ignored: RD_VALID stays 0.
REQ-028 EVENT_ACK in READOUT -> IDLE next cycle with EVENT_READY=0; a RD_REQ in the same cycle is still answered.
REQ-029 EVENT_ACK outside READOUT SHALL be ignored.

Reset
REQ-030 RST SHALL put the block in IDLE with counter, hit times, HIT_MASK, RD_DATA, RD_VALID, RD_HIT, EVENT_READY and BUSY all 0, from any state including mid-window.
REQ-031 RST SHALL take precedence over SCIN_COINC, RD_REQ and EVENT_ACK in the same cycle.

Configuration
REQ-032 With macro TUBE_HIT_MISSED_CNT_EN defined, the block SHALL add output MISSED_TRIG (8 bits), counting cycles with SCIN_COINC=1 in ARMED or READOUT.
REQ-033 MISSED_TRIG SHALL saturate at 255 and clear only on RST.
REQ-034 Without TUBE_HIT_MISSED_CNT_EN, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-035 A shared package SHALL hold the state enumeration and the default constants N_TUBES=4, CNT_W=8 and WINDOW_MAX=255.
REQ-036 Per-channel edge detect and first-hit latch SHALL be a sub-module tube_hit_channel, instantiated N_TUBES times.

Verification
REQ-037 Trigger; TUBE_IN[2] rises at counter 5; read channel 2 -> RD_DATA=5, RD_HIT=1; read channel 0 -> RD_DATA=0, RD_HIT=0.
REQ-038 Channels 0 and 3 rise in the same cycle at counter 10; channel 0 pulses again at 20 -> both store 10; HIT_MASK=4'b1001.
REQ-039 WINDOW_MAX=255 with a hit at counter 255 -> captured; EVENT_READY rises the next cycle; no wrap to 0.
REQ-040 SCIN_COINC pulsed at counter 30 and in READOUT -> no restart, stored times unchanged; with TUBE_HIT_MISSED_CNT_EN, MISSED_TRIG=2.
REQ-041 RST at counter 40 -> next cycle IDLE, all outputs 0; a new trigger records fresh times.
REQ-042 EVENT_ACK and RD_REQ in the same cycle -> RD_VALID=1 next cycle, state IDLE, EVENT_READY=0; a later RD_REQ gives no RD_VALID.
